// File: rtl/lab_pkg.sv
// -----------------------------------------------------------------
// lab_pkg: shared FSM state encoding and limits. Rev 1.0
// -----------------------------------------------------------------
`default_nettype none

package lab_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int WIDTH_MAX = 32;

endpackage

`default_nettype wire

// File: rtl/full_sub.sv
// -----------------------------------------------------------------
// full_sub: one-bit full-subtractor cell, d = a - b - bi. Rev 1.0
// -----------------------------------------------------------------
`default_nettype none

module full_sub (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~a & bi) | (b & bi);

endmodule

`default_nettype wire

// File: rtl/serial_sub.sv
// -----------------------------------------------------------------
// serial_sub: bit-serial two's-complement a - b, LSB first. Rev 1.0
// -----------------------------------------------------------------
`default_nettype none

module serial_sub
  import lab_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bo,
  output logic             ovf
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               br_q, br_d;
  logic               bo_q, bo_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               cell_d, cell_bo;

  full_sub u_cell (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .bi (br_q),
    .d  (cell_d),
    .bo (cell_bo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    br_d    = br_q;
    bo_d    = bo_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          cnt_d   = '0;
          br_d    = 1'b0;
          res_d   = '0;
          bo_d    = 1'b0;
          ovf_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d  = {cell_d, res_q[WIDTH-1:1]};
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        br_d   = cell_bo;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          // Overflow is the mismatch between borrow into and out of the sign bit.
          bo_d    = cell_bo;
          ovf_d   = br_q ^ cell_bo;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      bo_q    <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      br_q    <= br_d;
      bo_q    <= bo_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    assert (WIDTH >= 2 && WIDTH <= WIDTH_MAX);
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = res_q;
  assign bo   = bo_q;
  assign ovf  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_sub.sv
// -----------------------------------------------------------------
// tb_serial_sub: scoreboard bench for serial_sub at WIDTH 8 and 4. Rev 1.0
// -----------------------------------------------------------------
`default_nettype none

module tb_serial_sub;

  logic       clk = 1'b0;
  logic       reset;
  logic       start8, start4;
  logic [7:0] a8, b8, diff8;
  logic [3:0] a4, b4, diff4;
  logic       busy8, done8, bo8, ovf8;
  logic       busy4, done4, bo4, ovf4;

  int total = 0;
  int bad   = 0;
  int done8_cnt = 0;

  logic [9:0] sb8[$];
  logic [5:0] sb4[$];
  logic [9:0] e8;
  logic [5:0] e4;

  always #5 clk = ~clk;

  serial_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .bo(bo8), .ovf(ovf8)
  );

  serial_sub #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .bo(bo4), .ovf(ovf4)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference results packed as {diff, bo, ovf}.
  function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] d;
    d = a - b;
    return {d, (a < b), (a[7] != b[7]) && (d[7] != a[7])};
  endfunction

  function automatic logic [5:0] model4(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] d;
    d = a - b;
    return {d, (a < b), (a[3] != b[3]) && (d[3] != a[3])};
  endfunction

  always @(negedge clk) begin
    if (done8) begin
      done8_cnt++;
      if (sb8.size() == 0) check_val("done8_unexpected", 1, 0);
      else begin
        e8 = sb8.pop_front();
        check_val("diff8", diff8, e8[9:2]);
        check_val("bo8", bo8, e8[1]);
        check_val("ovf8", ovf8, e8[0]);
      end
    end
    if (done4) begin
      if (sb4.size() == 0) check_val("done4_unexpected", 1, 0);
      else begin
        e4 = sb4.pop_front();
        check_val("res4", {diff4, bo4, ovf4}, e4);
      end
    end
  end

  // Called on a falling edge; returns at the falling edge after the accept edge.
  task automatic accept8(input logic [7:0] a, input logic [7:0] b);
    a8 = a; b8 = b; start8 = 1'b1;
    sb8.push_back(model8(a, b));
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic wait_done8(output int n);
    n = 0;
    while (!done8 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!done8) check_val("timeout8", 0, 1);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b);
    int n;
    accept8(a, b);
    check_val("busy8_rise", busy8, 1);
    wait_done8(n);
    check_val("lat8", n, 8);
    @(negedge clk);
    check_val("busy8_fall", busy8, 0);
  endtask

  initial begin
    int n, idx, cyc, last, dc;
    logic prev_busy;
    reset = 1'b1; start8 = 1'b0; start4 = 1'b0;
    a8 = '0; b8 = '0; a4 = '0; b4 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_val("rst_busy", busy8, 0);
    check_val("rst_done", done8, 0);
    check_val("rst_diff", diff8, 0);
    check_val("rst_bo", bo8, 0);
    check_val("rst_ovf", ovf8, 0);

    op8(8'd5, 8'd3);
    op8(8'd3, 8'd5);
    op8(8'h80, 8'h01);
    op8(8'h7F, 8'hFF);

    // Starts during RUN and DONE must be ignored.
    dc = done8_cnt;
    accept8(8'h10, 8'h01);
    repeat (2) @(negedge clk);
    a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8(n);
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    check_val("ign_busy", busy8, 0);
    check_val("ign_done_cnt", done8_cnt - dc, 1);
    repeat (3) @(negedge clk);
    check_val("hold_diff", diff8, 8'h0F);

    // Abort with reset sampled on the fourth processing edge.
    accept8(8'h55, 8'h22);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    sb8.delete();
    @(negedge clk);
    reset = 1'b0;
    check_val("abort_busy", busy8, 0);
    check_val("abort_diff", diff8, 0);
    check_val("abort_bo", bo8, 0);
    check_val("abort_done", done8, 0);
    dc = done8_cnt;
    repeat (12) @(negedge clk);
    check_val("abort_no_done", done8_cnt - dc, 0);
    op8(8'd9, 8'd9);

    // WIDTH=4 exhaustive with start held high for back-to-back accepts.
    idx = 0; cyc = 0; last = 0; prev_busy = busy4;
    a4 = '0; b4 = '0; start4 = 1'b1;
    while (idx < 256 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (busy4 && !prev_busy) begin
        sb4.push_back(model4(a4, b4));
        if (idx > 0) check_val("space4", cyc - last, 6);
        last = cyc;
        idx++;
        {a4, b4} = idx[7:0];
        if (idx == 256) start4 = 1'b0;
      end
      prev_busy = busy4;
    end
    start4 = 1'b0;
    check_val("accepts4", idx, 256);
    repeat (10) @(negedge clk);
    check_val("sb4_drained", sb4.size(), 0);
    check_val("sb8_drained", sb8.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/serial_sub.md
# serial_sub

Bit-serial two's-complement subtractor: computes `a - b` one bit per clock, LSB first, using a single full-subtractor cell and a borrow flop. It is the subtracting counterpart to the team's full-adder datapath. It sits behind a start/done handshake so lab top-levels can drive it from switches or a controller FSM. It reports the difference, the unsigned borrow-out and the signed overflow.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range 2..32.
- `clk` input, 1: rising-edge clock.
- `reset` input, 1: synchronous, active-high; one clock; all state and outputs cleared on the next edge.
- `start` input, 1: request a subtraction; honoured only in IDLE.
- `a` input, WIDTH: minuend; sampled on the edge that accepts `start`.
- `b` input, WIDTH: subtrahend; sampled on the edge that accepts `start`.
- `busy` output, 1: high while an operation is in progress (RUN or DONE).
- `done` output, 1: one-cycle pulse when the result is valid.
- `diff` output, WIDTH: `a - b` mod 2^WIDTH.
- `bo` output, 1: borrow out; 1 iff `a < b` unsigned.
- `ovf` output, 1: signed overflow of `a - b`.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `start` = 1 on an edge: load `a` and `b` into shift registers, clear the borrow flop and bit counter, clear `diff` and `bo`, go to RUN.
  - `start` = 0: stay in IDLE.
- RUN: each edge processes bit i = counter, taking LSBs `ai`, `bi` of the shift registers and the current borrow `br`.
  - `d = ai ^ bi ^ br`
  - `br' = (~ai & bi) | (~ai & br) | (bi & br)`
  - `d` shifts into the result register from the MSB side; operands shift right; counter increments.
  - On the edge processing bit WIDTH-1:
    - `bo` takes `br'`.
    - `ovf` takes `br XOR br'`, i.e. borrow into MSB XOR borrow out of MSB.
    - Go to DONE.
- DONE: `done` = 1 for exactly one cycle, then IDLE. `diff`, `bo` and `ovf` hold until the next accepted `start` or `reset`.
- `start` in RUN or DONE is ignored; there is no queueing.
- `a` and `b` may change freely after the accept edge without affecting the result.
- `busy` = 1 in RUN and DONE; `done` = 1 only in DONE.
- Reset values: state IDLE, `busy` = 0, `done` = 0, `diff` = 0, `bo` = 0, `ovf` = 0; counter, borrow flop and shift registers all 0.
- `reset` mid-operation aborts immediately. The partial result is discarded and outputs return to their reset values. `reset` takes priority over a simultaneous `start`.

## Timing
- Accept edge E0 (IDLE, `start` = 1): `busy` rises after E0.
- Bits 0..WIDTH-1 are processed on edges E1..E_WIDTH.
- `done` is high in the cycle after E_WIDTH, i.e. sampled high at edge E_(WIDTH+1). `diff`, `bo` and `ovf` are valid in that same cycle.
- `busy` falls after E_(WIDTH+1). The earliest next accept edge is E_(WIDTH+2).
- Throughput: one operation per WIDTH+2 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `lab_pkg`: the state encoding enum (`IDLE`, `RUN`, `DONE`) and a `WIDTH_MAX` = 32 constant used by assertions.
- Sub-module `full_sub` (inputs `a`, `b`, `bi`; outputs `d`, `bo`): purely combinational, instantiated once. It is the bit cell; the borrow flop, counter and shift registers live in `serial_sub`.
- Counter width is `$clog2(WIDTH)`. Wrap is never reached, because the exit condition is `counter == WIDTH-1`.

## Test plan
- WIDTH=8, `a`=5, `b`=3 -> `done` at E9; `diff`=0x02, `bo`=0, `ovf`=0.
- WIDTH=8, `a`=3, `b`=5 -> `diff`=0xFE, `bo`=1, `ovf`=0.
- WIDTH=8, `a`=0x80, `b`=0x01 -> `diff`=0x7F, `bo`=0, `ovf`=1. Then `a`=0x7F, `b`=0xFF -> `diff`=0x80, `bo`=1, `ovf`=1.
- WIDTH=8, `a`=0x10, `b`=0x01 accepted; pulse `start` with `a`=0xFF, `b`=0 at E3 and in the DONE cycle -> both ignored; result 0x0F; `done` pulses exactly once.
- Assert `reset` at E4 of an operation -> next cycle `busy`=0, `diff`=0, no `done`. A new `start` with `a`=9, `b`=9 -> `diff`=0, `bo`=0, `ovf`=0.
- WIDTH=4, exhaustive over all 256 `a`/`b` pairs, back-to-back starts -> every result matches the reference model and every accept is spaced exactly 6 cycles apart.
